hilo_mul_ctrl: RTL

EX-stage controller that sits directly upstream of the iterative `multiply` unit and consumes its result.
- Decodes MULT/MULTU/MTHI/MTLO/MFHI/MFLO.
- Latches operands and holds `mult_begin` and the operands stable for the whole iteration.
- Stalls the pipeline until `mult_end`, then commits the 64-bit product into the architectural HI/LO registers.
- Serves MFHI/MFLO reads.

---
 rtl/hilo_mul_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/hilo_mul_ctrl.sv
// EX-stage HI/LO controller: decodes MULT/MULTU/MTHI/MTLO/MFHI/MFLO, drives the
// iterative multiplier with stable operands, stalls until mult_end, commits HI/LO.
module hilo_mul_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ex_valid,
  input  logic [2:0]         ex_op,
  input  logic [WIDTH-1:0]   ex_src1,
  input  logic [WIDTH-1:0]   ex_src2,
  input  logic               ex_flush,
  output logic               ex_stall,
  output logic [WIDTH-1:0]   mfhilo_data,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               mult_begin,
  output logic               mult_unsigned,
  output logic [WIDTH-1:0]   mult_op1,
  output logic [WIDTH-1:0]   mult_op2,
  input  logic [2*WIDTH-1:0] mult_product,
  input  logic               mult_end
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_MTHI  = 3'd3;
  localparam logic [2:0] OP_MTLO  = 3'd4;
  localparam logic [2:0] OP_MFHI  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic is_mul;
  logic ex_live;
  logic mul_start;

  assign is_mul    = ex_valid & ((ex_op == OP_MULT) | (ex_op == OP_MULTU));
  assign ex_live   = ex_valid & ~ex_flush;
  assign mul_start = (state == IDLE) & is_mul & ~ex_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // DONE always drops mult_begin for a cycle so the multiplier can clear and reload.
  always_comb begin
    state_next = state;
    ex_stall   = 1'b0;
    mult_begin = 1'b0;
    case (state)
      IDLE: begin
        if (mul_start) begin
          state_next = BUSY;
          ex_stall   = 1'b1;
        end
      end
      BUSY: begin
        mult_begin = 1'b1;
        ex_stall   = 1'b1;
        if (ex_flush) begin
          state_next = IDLE;
        end else if (mult_end) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operands only load in IDLE, so they stay frozen for the whole BUSY stretch.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi            <= '0;
      lo            <= '0;
      mult_op1      <= '0;
      mult_op2      <= '0;
      mult_unsigned <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mul_start) begin
            mult_op1      <= ex_src1;
            mult_op2      <= ex_src2;
            mult_unsigned <= (ex_op == OP_MULTU);
          end else if (ex_live && ex_op == OP_MTHI) begin
            hi <= ex_src1;
          end else if (ex_live && ex_op == OP_MTLO) begin
            lo <= ex_src1;
          end
        end
        BUSY: begin
          if (!ex_flush && mult_end) begin
            {hi, lo} <= mult_product;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mfhilo_data = (ex_op == OP_MFHI) ? hi : lo;

endmodule
